store_buffer: RTL

Store-side counterpart of the write-back load-extract path. Accepts store requests from the execute stage, aligns data to memory lanes and generates byte strobes. Queues requests in a small in-order FIFO and drains them to the data-memory port with a valid/ready handshake. Also flags misaligned stores and reports load-address hazards against pending stores.

---
 rtl/store_buffer_pkg.sv | 44 ++++
 rtl/store_buffer_st_align.sv | 33 +++
 rtl/store_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared store/load lane helpers: access-width encoding, byte sizes,
// strobe generation and alignment legality.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        ST_BYTE = 2'd0,
        ST_HALF = 2'd1,
        ST_WORD = 2'd2,
        ST_DBL  = 2'd3
    } st_width_e;

    function automatic logic [3:0] size_of(input st_width_e w);
        logic [3:0] sz;
        sz = 4'd8;
        case (w)
            ST_BYTE: sz = 4'd1;
            ST_HALF: sz = 4'd2;
            ST_WORD: sz = 4'd4;
            default: sz = 4'd8;
        endcase
        return sz;
    endfunction

    // Strobe for the widest (64-bit) lane; narrower datapaths truncate.
    function automatic logic [7:0] strb_gen(input st_width_e w, input logic [2:0] ofs);
        logic [7:0] base;
        base = 8'hFF;
        case (w)
            ST_BYTE: base = 8'h01;
            ST_HALF: base = 8'h03;
            ST_WORD: base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << ofs;
    endfunction

    function automatic logic misaligned(input st_width_e w, input logic [2:0] ofs,
                                        input logic rv64);
        logic [2:0] low_mask;
        low_mask = 3'(size_of(w) - 4'd1);
        return ((ofs & low_mask) != 3'd0) || ((w == ST_DBL) && !rv64);
    endfunction

endpackage

// File: rtl/store_buffer_st_align.sv
// Combinational store lane alignment: shifts data into its byte lanes,
// builds byte strobes and flags misaligned/illegal widths.
module st_align
    import store_buffer_pkg::*;
#(
    parameter int RV64       = 0,
    parameter int ADDR_WIDTH = 32,
    localparam int DATA_WIDTH = 32 * (1 + RV64),
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int OFS_W      = 2 + RV64
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_width,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic [STRB_WIDTH-1:0] o_strb,
    output logic                  o_illegal
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

    logic [OFS_W-1:0] w_ofs;
    st_width_e        w_width;

    assign w_ofs     = i_addr[OFS_W-1:0];
    assign w_width   = st_width_e'(i_width);
    assign o_addr    = i_addr & ADDR_MASK;
    assign o_dat     = i_dat << {w_ofs, 3'b000};
    assign o_strb    = STRB_WIDTH'(strb_gen(w_width, 3'(w_ofs)));
    assign o_illegal = misaligned(w_width, 3'(w_ofs), RV64 != 0);

endmodule

// File: rtl/store_buffer.sv
// In-order store queue: aligns execute-stage stores, buffers them in a small
// FIFO and drains to the data-memory port; also checks loads for hazards.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int RV64       = 0,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32,
    localparam int DATA_WIDTH = 32 * (1 + RV64),
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iStVld,
    output logic                  oStRdy,
    input  logic [ADDR_WIDTH-1:0] iStAddr,
    input  logic [1:0]            iStWidth,
    input  logic [DATA_WIDTH-1:0] iStDat,
    output logic                  oMemVld,
    input  logic                  iMemRdy,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0] oMemDat,
    output logic [STRB_WIDTH-1:0] oMemStrb,
    output logic                  oMisalign,
    output logic [ADDR_WIDTH-1:0] oMisalignAddr,
    input  logic                  iLdChkVld,
    input  logic [ADDR_WIDTH-1:0] iLdChkAddr,
    output logic                  oLdHit,
    output logic                  oEmpty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_dat  [DEPTH];
    logic [STRB_WIDTH-1:0] r_strb [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PTR_W-1:0]      r_rd;
    logic [PTR_W-1:0]      r_wr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mis;
    logic [ADDR_WIDTH-1:0] r_misaddr;

    logic [ADDR_WIDTH-1:0] w_al_addr;
    logic [DATA_WIDTH-1:0] w_al_dat;
    logic [STRB_WIDTH-1:0] w_al_strb;
    logic                  w_illegal;
    logic                  w_acc;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_ld_addr;
    logic                  w_hit;

    st_align #(
        .RV64       (RV64),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_align (
        .i_addr    (iStAddr),
        .i_width   (iStWidth),
        .i_dat     (iStDat),
        .o_addr    (w_al_addr),
        .o_dat     (w_al_dat),
        .o_strb    (w_al_strb),
        .o_illegal (w_illegal)
    );

    // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
    assign oStRdy  = (r_cnt != CNT_W'(DEPTH));
    assign oEmpty  = (r_cnt == '0);
    assign oMemVld = !oEmpty;
    assign w_acc   = iStVld && oStRdy;
    assign w_push  = w_acc && !w_illegal;
    assign w_pop   = oMemVld && iMemRdy;

    assign oMemAddr      = r_addr[r_rd];
    assign oMemDat       = r_dat[r_rd];
    assign oMemStrb      = r_strb[r_rd];
    assign oMisalign     = r_mis;
    assign oMisalignAddr = r_misaddr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_cnt     <= '0;
            r_vld     <= '0;
            r_mis     <= 1'b0;
            r_misaddr <= '0;
        end else begin
            r_mis <= w_acc && w_illegal;
            if (w_acc && w_illegal) begin
                r_misaddr <= iStAddr;
            end
            if (w_pop) begin
                r_vld[r_rd] <= 1'b0;
                r_rd        <= r_rd + 1'b1;
            end
            if (w_push) begin
                r_vld[r_wr] <= 1'b1;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr] <= w_al_addr;
            r_dat[r_wr]  <= w_al_dat;
            r_strb[r_wr] <= w_al_strb;
        end
    end

    assign w_ld_addr = iLdChkAddr & ADDR_MASK;

    always_comb begin
        w_hit = w_push && (w_al_addr == w_ld_addr);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[PTR_W'(i)] && (r_addr[i] == w_ld_addr)) begin
                w_hit = 1'b1;
            end
        end
        oLdHit = iLdChkVld && w_hit;
    end

endmodule
